alu_exec_stage: RTL and testbench
=================================

// Module: alu_exec_stage
// PURPOSE
//  Registered, parametrised execute stage: successor to the combinational ALU + operand-forward mux.
//  Accepts one op per cycle over valid/ready, resolves RAW hazards via tag-matched forwarding
//  (own result register, then writeback port), holds a Z,C,S,P flag register, runs an iterative
//  multi-cycle multiplier. Sits between operand-fetch (stage 2) and memory/writeback (stage 4).
// PARAMETERS
//  WIDTH    16  datapath width in bits (>=4)
//  RAW      3   register-tag width (2**RAW architectural registers)
//  MUL_EN   1   1 = MUL implemented; 0 = MUL executes as NOP (flags unchanged, out_wr=0)
// PORTS
//  clk        in   1       clock; all state on rising edge
//  rst_n      in   1       synchronous reset, active low
//  in_valid   in   1       op presented
//  in_ready   out  1       stage accepts op (transfer = in_valid & in_ready)
//  in_op      in   4       opcode (table in BEHAVIOUR)
//  in_a/in_b  in   WIDTH   operands read from register file
//  in_ta/in_tb in  RAW     source tags of in_a/in_b
//  in_dst     in   RAW     destination tag
//  in_wr      in   1       op writes in_dst
//  wb_valid   in   1       writeback port carries a register write this cycle
//  wb_dst     in   RAW     writeback tag
//  wb_data    in   WIDTH   writeback value
//  out_valid  out  1       result register holds an un-consumed result
//  out_ready  in   1       downstream consumes (transfer = out_valid & out_ready)
//  out_data   out  WIDTH   result
//  out_dst    out  RAW     destination tag of result
//  out_wr     out  1       result is a register write
//  flags      out  4       {Z,C,S,P} flag register
//  busy       out  1       multiplier in progress
// BEHAVIOUR
//  Reset: out_valid=0, out_data=0, out_dst=0, out_wr=0, flags=0, busy=0, FSM=IDLE; abandons any MUL.
//  Ops: 0 ADD,1 ADC(+C),2 SUB(a-b),3 SBB(a-b-C),4 AND,5 OR,6 XOR,7 NOT a,8 SHL a by 1,9 SHR a by 1
//   (logical),A INC a,B DEC a,C MOV b,D CMP(a-b, flags only, out_wr forced 0),E MUL(low WIDTH),F NOP.
//  Operand select (per operand, priority): own result reg if out_valid&out_wr&tag==out_dst;
//   else wb_data if wb_valid&tag==wb_dst; else in_a/in_b. Evaluated in the accept cycle.
//  in_ready = ~busy & (~out_valid | out_ready). Result reg loads on accept (single-cycle ops,
//   latency 1) or on MUL completion; holds unchanged while out_valid & ~out_ready.
//  out_valid clears on consume when nothing new loads; consume+load same cycle keeps it 1.
//  NOP/non-impl MUL: accepted, loads result reg with out_wr=0, out_data=0; flags unchanged.
//  Flags load together with result reg: Z=(r==0), S=r[WIDTH-1], P=~^r (1 = even ones).
//   C: ADD/ADC/INC carry-out; SUB/SBB/CMP/DEC borrow; SHL bit shifted out of MSB; SHR bit out of
//   LSB; MUL C=|high WIDTH bits; AND/OR/XOR/NOT/MOV C=0. MOV updates Z,S,P too.
//  ADC/SBB use flag register C as it stands in the accept cycle.
//  MUL FSM: IDLE -(accept MUL)-> RUN: latch forwarded a,b, acc=0, cnt=WIDTH, busy=1; each RUN
//   cycle shift-add one multiplier bit (2*WIDTH product), cnt--; cnt==0 -> DONE. DONE waits
//   for ~out_valid|out_ready, loads result reg+flags, busy=0, -> IDLE. Min latency WIDTH+1 cycles.
//  While busy: in_ready=0; result reg may still drain. Reset in RUN/DONE -> IDLE, no result.
//  Arithmetic: WIDTH+1-bit sums; INC/DEC wrap modulo 2**WIDTH.
// STRUCTURE
//  Package alu_exec_pkg: opcode localparams, flag bit indices, FSM state enum (IDLE/RUN/DONE).
//  Sub-module alu_mul_iter: iterative shift-add multiplier (start, a, b -> done, product[2W]).
//  Top holds forward muxes, combinational ALU, result/flag registers, handshake.
// TESTING (WIDTH=8)
//  ADD FF+01 -> out_data=00, flags Z=1,C=1,S=0,P=1, out_valid one cycle after accept.
//  ADD r1<=05+03 then back-to-back SUB r2<=r1-01 with stale in_a=00 -> out_data 07 (own fwd);
//   repeat with r1 only on wb port -> 07 via wb forward.
//  MUL 0D*0B -> 8F, C=0, busy for 9 cycles, in_ready=0 meanwhile; MUL 14*14 -> 90, C=1.
//  out_ready=0 for 5 cycles after ADD: out_data/flags stable, in_ready=0; release -> next op flows.
//  rst_n=0 mid-MUL (cycle 4): next cycle busy=0,out_valid=0,flags=0; no MUL result ever emitted.
//  CMP 03-05: out_wr=0, C=1, S=1, Z=0; then SBB 10-01 -> out_data 0E.

Source files
------------

// File: rtl/alu_exec_pkg.sv
// alu_exec_pkg: opcodes, flag bit positions and multiplier FSM states shared by the execute stage
package alu_exec_pkg;
  localparam logic [3:0] OP_ADD = 4'h0, OP_ADC = 4'h1, OP_SUB = 4'h2, OP_SBB = 4'h3,
                         OP_AND = 4'h4, OP_OR  = 4'h5, OP_XOR = 4'h6, OP_NOT = 4'h7,
                         OP_SHL = 4'h8, OP_SHR = 4'h9, OP_INC = 4'hA, OP_DEC = 4'hB,
                         OP_MOV = 4'hC, OP_CMP = 4'hD, OP_MUL = 4'hE, OP_NOP = 4'hF;
  localparam int F_Z = 3, F_C = 2, F_S = 1, F_P = 0;
  typedef enum logic [1:0] {IDLE, RUN, DONE} mul_state_t;
endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: iterative shift-add multiplier, one multiplier bit per cycle, holds product until taken
module alu_mul_iter import alu_exec_pkg::*; #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 take,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);
  localparam int CW = $clog2(WIDTH + 1);
  mul_state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH:0] sum;
  always_ff @(posedge clk) state <= !rst_n ? IDLE : nxt;
  always_comb begin
    nxt = state == IDLE ? (start ? RUN : IDLE) :
          state == RUN  ? (cnt == CW'(1) ? DONE : RUN) :
                          (take ? IDLE : DONE);
  end
  always_comb begin
    busy = state != IDLE;
    done = state == DONE;
  end
  // upper half accumulates; multiplier bits shift out of the lower half as product bits shift in
  assign sum = {1'b0, product[2*WIDTH-1:WIDTH]} + (product[0] ? {1'b0, mcand} : '0);
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      mcand   <= a;
      product <= {{WIDTH{1'b0}}, b};
      cnt     <= CW'(WIDTH);
    end else if (state == RUN) begin
      product <= {sum, product[WIDTH-1:1]};
      cnt     <= cnt - CW'(1);
    end
  end
endmodule

// File: rtl/alu_exec_stage.sv
// alu_exec_stage: registered execute stage with tag-matched forwarding, flag register and iterative MUL
module alu_exec_stage import alu_exec_pkg::*; #(
  parameter int WIDTH  = 16,
  parameter int RAW    = 3,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [RAW-1:0]   in_ta,
  input  logic [RAW-1:0]   in_tb,
  input  logic [RAW-1:0]   in_dst,
  input  logic             in_wr,
  input  logic             wb_valid,
  input  logic [RAW-1:0]   wb_dst,
  input  logic [WIDTH-1:0] wb_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [RAW-1:0]   out_dst,
  output logic             out_wr,
  output logic [3:0]       flags,
  output logic             busy
);
  logic [WIDTH-1:0] fa, fb, fr;
  logic [WIDTH:0] s;
  logic [2*WIDTH-1:0] prod;
  logic [RAW-1:0] mul_dst;
  logic [3:0] nf;
  logic alu_wr, alu_fl, fc, accept, mul_start, mul_busy, mul_done, load_mul, load_alu, mul_wr;
  // own result register wins over the writeback port: it holds the younger value
  assign fa = (out_valid && out_wr && in_ta == out_dst) ? out_data :
              (wb_valid && in_ta == wb_dst) ? wb_data : in_a;
  assign fb = (out_valid && out_wr && in_tb == out_dst) ? out_data :
              (wb_valid && in_tb == wb_dst) ? wb_data : in_b;
  assign busy      = mul_busy;
  assign in_ready  = ~mul_busy & (~out_valid | out_ready);
  assign accept    = in_valid & in_ready;
  assign mul_start = accept && MUL_EN && in_op == OP_MUL;
  assign load_mul  = mul_done & (~out_valid | out_ready);
  assign load_alu  = accept & ~mul_start;
  always_comb begin
    s      = '0;
    alu_wr = in_wr;
    alu_fl = 1'b1;
    case (in_op)
      OP_ADD:         s = {1'b0, fa} + {1'b0, fb};
      OP_ADC:         s = {1'b0, fa} + {1'b0, fb} + {{WIDTH{1'b0}}, flags[F_C]};
      OP_SUB, OP_CMP: s = {1'b0, fa} - {1'b0, fb};
      OP_SBB:         s = {1'b0, fa} - {1'b0, fb} - {{WIDTH{1'b0}}, flags[F_C]};
      OP_AND:         s = {1'b0, fa & fb};
      OP_OR:          s = {1'b0, fa | fb};
      OP_XOR:         s = {1'b0, fa ^ fb};
      OP_NOT:         s = {1'b0, ~fa};
      OP_SHL:         s = {fa, 1'b0};
      OP_SHR:         s = {fa[0], 1'b0, fa[WIDTH-1:1]};
      OP_INC:         s = {1'b0, fa} + (WIDTH+1)'(1);
      OP_DEC:         s = {1'b0, fa} - (WIDTH+1)'(1);
      OP_MOV:         s = {1'b0, fb};
      default: begin
        alu_wr = 1'b0;
        alu_fl = 1'b0;
      end
    endcase
    if (in_op == OP_CMP) alu_wr = 1'b0;
  end
  always_comb begin
    fr      = load_mul ? prod[WIDTH-1:0] : s[WIDTH-1:0];
    fc      = load_mul ? |prod[2*WIDTH-1:WIDTH] : s[WIDTH];
    nf      = '0;
    nf[F_Z] = fr == '0;
    nf[F_C] = fc;
    nf[F_S] = fr[WIDTH-1];
    nf[F_P] = ~^fr;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_dst   <= '0;
      out_wr    <= 1'b0;
      flags     <= '0;
    end else if (load_mul || load_alu) begin
      out_valid <= 1'b1;
      out_data  <= fr;
      out_dst   <= load_mul ? mul_dst : in_dst;
      out_wr    <= load_mul ? mul_wr : alu_wr;
      if (load_mul || alu_fl) flags <= nf;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (mul_start) begin
      mul_dst <= in_dst;
      mul_wr  <= in_wr;
    end
  end
  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk(clk), .rst_n(rst_n), .start(mul_start), .take(load_mul),
    .a(fa), .b(fb), .busy(mul_busy), .done(mul_done), .product(prod)
  );
endmodule

// File: tb/tb_alu_exec_stage.sv
// tb_alu_exec_stage: directed cases plus random traffic against an arithmetic reference model (WIDTH=8)
module tb_alu_exec_stage;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, in_wr = 1'b0, wb_valid = 1'b0, out_ready = 1'b1;
  logic [3:0] in_op = '0;
  logic [7:0] in_a = '0, in_b = '0, wb_data = '0;
  logic [2:0] in_ta = '0, in_tb = '0, in_dst = '0, wb_dst = '0;
  logic in_ready, out_valid, out_wr, busy;
  logic [7:0] out_data;
  logic [2:0] out_dst;
  logic [3:0] flags;
  int total = 0, bad = 0;
  bit m_valid, m_wr, m_busy, m_mwr;
  logic [7:0] m_data;
  logic [2:0] m_dst, m_mdst;
  logic [3:0] m_flags;
  int m_left, m_mres;

  alu_exec_stage #(.WIDTH(8), .RAW(3), .MUL_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_ta(in_ta), .in_tb(in_tb), .in_dst(in_dst), .in_wr(in_wr),
    .wb_valid(wb_valid), .wb_dst(wb_dst), .wb_data(wb_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_dst(out_dst), .out_wr(out_wr),
    .flags(flags), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic mreset();
    m_valid = 0; m_wr = 0; m_busy = 0; m_data = '0; m_dst = '0; m_flags = '0; m_left = 0;
  endtask

  task automatic mload(int r, bit c, logic [2:0] d, bit w, bit upd);
    logic [7:0] rr;
    rr = 8'(r);
    m_valid = 1; m_data = rr; m_dst = d; m_wr = w;
    if (upd) m_flags = {rr == 0, c, rr >= 128, $countones(rr) % 2 == 0};
  endtask

  function automatic int fwd(logic [2:0] t, logic [7:0] raw);
    if (m_valid && m_wr && t == m_dst) return int'(m_data);
    if (wb_valid && t == wb_dst) return int'(wb_data);
    return int'(raw);
  endfunction

  // one clock of the architectural model, using the inputs currently driven
  task automatic step();
    int a, b, t, cin;
    bit c, w;
    if (!rst_n) begin
      mreset();
      return;
    end
    if (m_busy) begin
      if (m_left > 0) begin
        m_left--;
        if (out_ready) m_valid = 0;
      end else if (!m_valid || out_ready) begin
        mload(m_mres, m_mres > 255, m_mdst, m_mwr, 1);
        m_busy = 0;
      end
    end else if (in_valid && (!m_valid || out_ready)) begin
      a = fwd(in_ta, in_a);
      b = fwd(in_tb, in_b);
      cin = int'(m_flags[2]);
      if (in_op == 4'hE) begin
        m_busy = 1; m_left = 8; m_mres = a * b; m_mdst = in_dst; m_mwr = in_wr;
        if (out_ready) m_valid = 0;
      end else if (in_op == 4'hF) begin
        mload(0, 0, in_dst, 0, 0);
      end else begin
        case (in_op)
          4'h0: t = a + b;
          4'h1: t = a + b + cin;
          4'h2, 4'hD: t = a - b;
          4'h3: t = a - b - cin;
          4'h4: t = a & b;
          4'h5: t = a | b;
          4'h6: t = a ^ b;
          4'h7: t = 255 - a;
          4'h8: t = 2 * a;
          4'h9: t = a / 2;
          4'hA: t = a + 1;
          4'hB: t = a - 1;
          default: t = b;
        endcase
        c = (t < 0) || (t > 255);
        if (in_op == 4'h9) c = (a % 2) == 1;
        w = in_wr && in_op != 4'hD;
        mload(t & 255, c, in_dst, w, 1);
      end
    end else if (out_ready) begin
      m_valid = 0;
    end
  endtask

  task automatic cyc();
    #1;
    chk("in_ready", in_ready, !m_busy && (!m_valid || out_ready));
    step();
    @(posedge clk);
    #1;
    chk("out_valid", out_valid, m_valid);
    chk("out_data", out_data, m_data);
    chk("out_dst", out_dst, m_dst);
    chk("out_wr", out_wr, m_wr);
    chk("flags", flags, m_flags);
    chk("busy", busy, m_busy);
  endtask

  task automatic op(logic [3:0] o, logic [7:0] a, logic [7:0] b, logic [2:0] ta, logic [2:0] tb,
                    logic [2:0] d, logic w);
    in_valid = 1; in_op = o; in_a = a; in_b = b; in_ta = ta; in_tb = tb; in_dst = d; in_wr = w;
    cyc();
    in_valid = 0;
  endtask

  function automatic logic [7:0] rv();
    case ($urandom_range(0, 5))
      0: return 8'h00;
      1: return 8'hFF;
      2: return 8'h80;
      3: return 8'h01;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1;
    mreset();
    chk("rst_valid", out_valid, 0);
    chk("rst_flags", flags, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1;
    op(4'h0, 8'hFF, 8'h01, 0, 0, 3, 1);
    chk("add_valid", out_valid, 1);
    chk("add_data", out_data, 8'h00);
    chk("add_flags", flags, 4'b1101);
    op(4'h0, 8'h05, 8'h03, 0, 0, 1, 1);
    op(4'h2, 8'h00, 8'h01, 1, 0, 2, 1);
    chk("own_fwd", out_data, 8'h07);
    op(4'hF, 8'h00, 8'h00, 0, 0, 0, 0);
    wb_valid = 1; wb_dst = 1; wb_data = 8'h08;
    op(4'h2, 8'h00, 8'h01, 1, 0, 2, 1);
    wb_valid = 0;
    chk("wb_fwd", out_data, 8'h07);
    op(4'hE, 8'h0D, 8'h0B, 0, 0, 4, 1);
    n = 0;
    while (busy && n < 30) begin
      n++;
      cyc();
    end
    chk("mul_lat", n, 9);
    chk("mul_data", out_data, 8'h8F);
    chk("mul_c", flags[2], 0);
    op(4'hE, 8'h14, 8'h14, 5, 5, 5, 1);
    n = 0;
    while (busy && n < 30) begin
      n++;
      cyc();
    end
    chk("mul2_data", out_data, 8'h90);
    chk("mul2_c", flags[2], 1);
    op(4'h0, 8'h22, 8'h11, 0, 0, 6, 1);
    out_ready = 0;
    in_valid = 1; in_op = 4'hC; in_b = 8'h55; in_tb = 0; in_dst = 7; in_wr = 0;
    repeat (5) begin
      cyc();
      chk("stall_data", out_data, 8'h33);
      chk("stall_rdy", in_ready, 0);
    end
    out_ready = 1;
    cyc();
    in_valid = 0;
    chk("release_data", out_data, 8'h55);
    op(4'hD, 8'h03, 8'h05, 0, 0, 0, 1);
    chk("cmp_wr", out_wr, 0);
    chk("cmp_zcs", flags[3:1], 3'b011);
    op(4'h3, 8'h10, 8'h01, 0, 0, 1, 1);
    chk("sbb_data", out_data, 8'h0E);
    op(4'hE, 8'h02, 8'h03, 0, 0, 2, 1);
    repeat (3) cyc();
    rst_n = 0;
    cyc();
    rst_n = 1;
    chk("mrst_busy", busy, 0);
    chk("mrst_valid", out_valid, 0);
    chk("mrst_flags", flags, 0);
    repeat (15) begin
      cyc();
      chk("mrst_quiet", out_valid, 0);
    end
    for (int i = 0; i < 1500; i++) begin
      in_valid = $urandom_range(0, 9) < 7;
      in_op = 4'($urandom);
      in_a = rv(); in_b = rv();
      in_ta = 3'($urandom); in_tb = 3'($urandom); in_dst = 3'($urandom);
      in_wr = $urandom_range(0, 3) != 0;
      wb_valid = 1'($urandom); wb_dst = 3'($urandom); wb_data = rv();
      out_ready = $urandom_range(0, 3) != 0;
      rst_n = $urandom_range(0, 199) != 0;
      cyc();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
